icache_fill: RTL and testbench

ICACHE_FILL -- requirements
Module: icache_fill

---
 rtl/icache_fill_pkg.sv | 21 ++
 rtl/icache_mem.sv | 40 ++++
 rtl/icache_fill.sv | 98 +++++++++
 tb/tb_icache_fill.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/icache_fill_pkg.sv
// Shared types and constants for the instruction-cache fill block.
package icache_fill_pkg;
    localparam int XLEN = 32;

    localparam logic [1:0] BUS_NONE = 2'h0;
    localparam logic [1:0] BUS_LOAD = 2'h1;

    // Widest tag, reached with the smallest legal cache (2 lines).
    localparam int TAG_MAX_W = XLEN - 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fill_state_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
    } icache_line_t;
endpackage

// File: rtl/icache_mem.sv
// Direct-mapped line storage: one combinational read port, one synchronous write port.
module icache_mem
    import icache_fill_pkg::*;
#(
    parameter int LINES = 32,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [IDX_W-1:0]     rd_idx_i,
    output icache_line_t         rd_line_o,
    output logic [63:0]          rd_data_o,
    input  logic                 wr_en_i,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  logic [TAG_MAX_W-1:0] wr_tag_i,
    input  logic [63:0]          wr_data_i
);
    logic [LINES-1:0]     valid_q;
    logic [TAG_MAX_W-1:0] tag_q  [LINES];
    logic [63:0]          data_q [LINES];

    always_ff @(posedge clock) begin
        if (!reset)
            valid_q <= '0;
        else if (wr_en_i)
            valid_q[wr_idx_i] <= 1'b1;
    end

    // Tag and data contents are meaningless until their valid bit is set.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_line_o.valid = valid_q[rd_idx_i];
    assign rd_line_o.tag   = tag_q[rd_idx_i];
    assign rd_data_o       = data_q[rd_idx_i];
endmodule

// File: rtl/icache_fill.sv
// Instruction cache lookup with a single-outstanding-miss fill FSM.
module icache_fill
    import icache_fill_pkg::*;
#(
    parameter int ICACHE_LINES = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] proc2Icache_addr,
    output logic [63:0]     Icache_data_out,
    output logic            Icache_valid_out,
    output logic [1:0]      Icache2ctrl_command,
    output logic [XLEN-1:0] Icache2ctrl_addr,
    input  logic [3:0]      ctrl2Icache_response,
    input  logic [63:0]     ctrl2Icache_data,
    input  logic [3:0]      ctrl2Icache_tag,
    input  logic            dcache_request
);
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = XLEN - 3 - IDX_W;

    fill_state_e     state_q, state_d;
    logic [XLEN-1:0] miss_addr_q, miss_addr_d;
    logic [3:0]      pend_tag_q, pend_tag_d;

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    icache_line_t     rd_line;
    logic             hit;
    logic             wr_en;

    assign rd_idx = proc2Icache_addr[IDX_W+2:3];
    assign rd_tag = proc2Icache_addr[XLEN-1:IDX_W+3];

    logic unused_offset;
    assign unused_offset = ^proc2Icache_addr[2:0];

    icache_mem #(.LINES(ICACHE_LINES), .IDX_W(IDX_W)) u_mem (
        .clock    (clock),
        .reset    (reset),
        .rd_idx_i (rd_idx),
        .rd_line_o(rd_line),
        .rd_data_o(Icache_data_out),
        .wr_en_i  (wr_en),
        .wr_idx_i (miss_addr_q[IDX_W+2:3]),
        .wr_tag_i (TAG_MAX_W'(miss_addr_q[XLEN-1:IDX_W+3])),
        .wr_data_i(ctrl2Icache_data)
    );

    assign hit              = rd_line.valid && (rd_line.tag == TAG_MAX_W'(rd_tag));
    assign Icache_valid_out = hit;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            pend_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            pend_tag_q  <= pend_tag_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        miss_addr_d         = miss_addr_q;
        pend_tag_d          = pend_tag_q;
        Icache2ctrl_command = BUS_NONE;
        Icache2ctrl_addr    = '0;
        wr_en               = 1'b0;
        case (state_q)
            IDLE: begin
                if (!hit) begin
                    miss_addr_d = {proc2Icache_addr[XLEN-1:3], 3'b000};
                    state_d     = REQ;
                end
            end
            REQ: begin
                Icache2ctrl_command = BUS_LOAD;
                Icache2ctrl_addr    = miss_addr_q;
                // While the Dcache owns the bus the response is its grant, not ours.
                if (!dcache_request && ctrl2Icache_response != 4'd0) begin
                    pend_tag_d = ctrl2Icache_response;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (ctrl2Icache_tag != 4'd0 && ctrl2Icache_tag == pend_tag_q) begin
                    wr_en      = 1'b1;
                    pend_tag_d = 4'd0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_icache_fill.sv
// Directed scoreboard bench for icache_fill (32 lines).
module tb_icache_fill;
    import icache_fill_pkg::*;

    logic            clock;
    logic            reset;
    logic [XLEN-1:0] proc2Icache_addr;
    logic [63:0]     Icache_data_out;
    logic            Icache_valid_out;
    logic [1:0]      Icache2ctrl_command;
    logic [XLEN-1:0] Icache2ctrl_addr;
    logic [3:0]      ctrl2Icache_response;
    logic [63:0]     ctrl2Icache_data;
    logic [3:0]      ctrl2Icache_tag;
    logic            dcache_request;

    icache_fill #(.ICACHE_LINES(32)) dut (
        .clock               (clock),
        .reset               (reset),
        .proc2Icache_addr    (proc2Icache_addr),
        .Icache_data_out     (Icache_data_out),
        .Icache_valid_out    (Icache_valid_out),
        .Icache2ctrl_command (Icache2ctrl_command),
        .Icache2ctrl_addr    (Icache2ctrl_addr),
        .ctrl2Icache_response(ctrl2Icache_response),
        .ctrl2Icache_data    (ctrl2Icache_data),
        .ctrl2Icache_tag     (ctrl2Icache_tag),
        .dcache_request      (dcache_request)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        v;
        logic        chk_d;
        logic [63:0] d;
        logic [1:0]  cmd;
        logic [31:0] caddr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [63:0] D1 = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] D2 = 64'h01234567_89ABCDEF;
    localparam logic [63:0] D3 = 64'hAAAA5555_AAAA5555;
    localparam logic [63:0] D4 = 64'h44440000_44440000;
    localparam logic [63:0] DX = 64'h0BAD0BAD_0BAD0BAD;

    // Drive one cycle of inputs shortly after the rising edge.
    task automatic cyc(input logic [31:0] a, input logic [3:0] rsp, input logic [3:0] tg,
                       input logic [63:0] dat, input logic dr, input logic rs);
        @(posedge clock);
        #1;
        reset                = rs;
        proc2Icache_addr     = a;
        ctrl2Icache_response = rsp;
        ctrl2Icache_tag      = tg;
        ctrl2Icache_data     = dat;
        dcache_request       = dr;
    endtask

    task automatic exp_out(input string n, input logic v, input logic cd, input logic [63:0] d,
                           input logic [1:0] c, input logic [31:0] ca);
        exp_t e;
        e.name = n; e.v = v; e.chk_d = cd; e.d = d; e.cmd = c; e.caddr = ca;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (Icache_valid_out !== e.v) begin
                    errors++;
                    $display("FAIL %s valid_out got %0b want %0b", e.name, Icache_valid_out, e.v);
                end
                checks++;
                if (Icache2ctrl_command !== e.cmd) begin
                    errors++;
                    $display("FAIL %s command got %0d want %0d", e.name, Icache2ctrl_command, e.cmd);
                end
                checks++;
                if (Icache2ctrl_addr !== e.caddr) begin
                    errors++;
                    $display("FAIL %s ctrl_addr got %h want %h", e.name, Icache2ctrl_addr, e.caddr);
                end
                if (e.chk_d) begin
                    checks++;
                    if (Icache_data_out !== e.d) begin
                        errors++;
                        $display("FAIL %s data got %h want %h", e.name, Icache_data_out, e.d);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b0; proc2Icache_addr = 32'h100; ctrl2Icache_response = 4'd0;
        ctrl2Icache_tag = 4'd0; ctrl2Icache_data = 64'd0; dcache_request = 1'b0;

        // Reset, first miss on 0x100, grant tag 3, fill, hit on 0x104
        cyc(32'h100, 0, 0, 0, 0, 0); exp_out("rst0",       0, 0, 0, BUS_NONE, 32'h0);
        cyc(32'h100, 0, 0, 0, 0, 1); exp_out("rst1",       0, 0, 0, BUS_NONE, 32'h0);
        cyc(32'h100, 0, 0, 0, 0, 1); exp_out("req_busy",   0, 0, 0, BUS_LOAD, 32'h100);
        cyc(32'h100, 3, 0, 0, 0, 1); exp_out("req_grant",  0, 0, 0, BUS_LOAD, 32'h100);
        cyc(32'h100, 0, 0, 0, 0, 1); exp_out("wait0",      0, 0, 0, BUS_NONE, 32'h0);
        cyc(32'h100, 0, 3, D1, 0, 1); exp_out("fill_nofwd", 0, 0, 0, BUS_NONE, 32'h0);
        cyc(32'h104, 0, 0, 0, 0, 1); exp_out("hit_104",    1, 1, D1, BUS_NONE, 32'h0);

        // Dcache owns the bus; wrong-tag completion ignored
        cyc(32'h048, 0, 0, 0, 0, 1); exp_out("miss_048",   0, 0, 0, BUS_NONE, 32'h0);
        cyc(32'h048, 5, 0, 0, 1, 1); exp_out("dreq0",      0, 0, 0, BUS_LOAD, 32'h48);
        cyc(32'h100, 5, 0, 0, 1, 1); exp_out("dreq1_hit",  1, 1, D1, BUS_LOAD, 32'h48);
        cyc(32'h048, 5, 0, 0, 1, 1); exp_out("dreq2",      0, 0, 0, BUS_LOAD, 32'h48);
        cyc(32'h048, 6, 0, 0, 0, 1); exp_out("grant6",     0, 0, 0, BUS_LOAD, 32'h48);
        cyc(32'h048, 0, 5, 64'h1111, 0, 1); exp_out("tag5_ign", 0, 0, 0, BUS_NONE, 32'h0);
        cyc(32'h048, 7, 0, 0, 0, 1); exp_out("wait_rsp_ign", 0, 0, 0, BUS_NONE, 32'h0);
        cyc(32'h048, 0, 6, D2, 0, 1); exp_out("fill6",      0, 0, 0, BUS_NONE, 32'h0);
        cyc(32'h048, 0, 0, 0, 0, 1); exp_out("hit_048",    1, 1, D2, BUS_NONE, 32'h0);

        // Conflict replacement on index 0
        cyc(32'h200, 0, 0, 0, 0, 1); exp_out("miss_200",   0, 0, 0, BUS_NONE, 32'h0);
        cyc(32'h200, 1, 0, 0, 0, 1); exp_out("req_200",    0, 0, 0, BUS_LOAD, 32'h200);
        cyc(32'h100, 0, 0, 0, 0, 1); exp_out("old_hit_w",  1, 1, D1, BUS_NONE, 32'h0);
        cyc(32'h100, 0, 1, D3, 0, 1); exp_out("old_hit_f",  1, 1, D1, BUS_NONE, 32'h0);
        cyc(32'h200, 0, 0, 0, 0, 1); exp_out("hit_200",    1, 1, D3, BUS_NONE, 32'h0);
        cyc(32'h100, 0, 0, 0, 0, 1); exp_out("evicted",    0, 0, 0, BUS_NONE, 32'h0);

        // Reset while waiting abandons the miss
        cyc(32'h100, 2, 0, 0, 0, 1); exp_out("req_100b",   0, 0, 0, BUS_LOAD, 32'h100);
        cyc(32'h100, 0, 0, 0, 0, 0); exp_out("wait_rst",   0, 0, 0, BUS_NONE, 32'h0);
        cyc(32'h100, 0, 2, DX, 0, 1); exp_out("stale_tag",  0, 0, 0, BUS_NONE, 32'h0);
        cyc(32'h100, 4, 0, 0, 0, 1); exp_out("no_write",   0, 0, 0, BUS_LOAD, 32'h100);

        // Fetch address moves during WAIT; fill still targets 0x100
        cyc(32'h300, 0, 0, 0, 0, 1); exp_out("wait_300",   0, 0, 0, BUS_NONE, 32'h0);
        cyc(32'h300, 0, 4, D4, 0, 1); exp_out("fill4",      0, 0, 0, BUS_NONE, 32'h0);
        cyc(32'h300, 0, 0, 0, 0, 1); exp_out("miss_300",   0, 0, 0, BUS_NONE, 32'h0);
        cyc(32'h100, 0, 0, 0, 0, 1); exp_out("req300_hit", 1, 1, D4, BUS_LOAD, 32'h300);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
